shr_frame_seq: RTL and testbench

- Sequencer for the serial shift-register chain driven on GPIO: serialises a frame onto sclk/sdo and closes it with a syn latch pulse.
- Arbitrates three load requesters: a load key (trig), a clear key (dump) and an internal auto-refresh timer.
- Sits between the board keys and the GPIO header, clocked by the PLL output.

---
 rtl/shr_frame_seq.sv | 169 ++++++++++++++++
 tb/tb_shr_frame_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/shr_frame_seq.sv
// Frame sequencer for a GPIO shift-register chain: serialises a word MSB
// first on sclk/sdo, closes it with a syn latch strobe, and arbitrates the
// load key, the clear key and an optional auto-refresh timer.
module shr_frame_seq #(
    parameter int WIDTH       = 16,
    parameter int DIV         = 4,
    parameter int AUTO_PERIOD = 0
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             trig,
    input  logic             dump,
    input  logic             auto_en,
    input  logic [WIDTH-1:0] data_a,
    output logic             sclk,
    output logic             sdo,
    output logic             syn,
    output logic             busy,
    output logic             done,
    output logic             out_en,
    output logic             valid
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam int TW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_e;

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;
    logic [2:0]       trig_q, dump_q;
    logic             trig_rise, dump_rise;
    logic [TW-1:0]    timer_q, timer_d;
    logic             tick;
    logic             pend_load_q, pend_load_d, pend_clr_q, pend_clr_d;
    logic             take_load, take_clr;
    state_e           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             kind_q, kind_d;   // 1 = data frame, 0 = clear frame
    logic             div_last, shifting_d;
    logic             done_d, valid_d;

    // Reset asserts asynchronously, releases two clocks later in clk_in domain
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    // Two-flop synchronisers plus one history flop for edge detection on the keys
    always_ff @(posedge clk_in or negedge rst_int_n) begin
        if (!rst_int_n) begin
            trig_q <= '0;
            dump_q <= '0;
        end else begin
            trig_q <= {trig_q[1:0], trig};
            dump_q <= {dump_q[1:0], dump};
        end
    end
    assign trig_rise = trig_q[1] & ~trig_q[2];
    assign dump_rise = dump_q[1] & ~dump_q[2];

    // Auto-refresh timer: free-runs while enabled, held at zero otherwise
    always_comb begin
        timer_d = '0;
        tick    = 1'b0;
        if (AUTO_PERIOD > 0 && auto_en) begin
            if (timer_q == TW'(AUTO_PERIOD - 1)) tick = 1'b1;
            else                                 timer_d = timer_q + 1'b1;
        end
    end

    // Next-state logic: clear beats load in IDLE; LATCH exit publishes done/valid
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        kind_d    = kind_q;
        take_load = 1'b0;
        take_clr  = 1'b0;
        done_d    = 1'b0;
        valid_d   = valid;
        div_last  = (div_q == DW'(DIV - 1));
        case (state_q)
            IDLE: begin
                if (pend_clr_q || pend_load_q) begin
                    take_clr  = pend_clr_q;
                    take_load = !pend_clr_q;
                    shreg_d   = pend_clr_q ? '0 : data_a;
                    kind_d    = !pend_clr_q;
                    div_d     = '0;
                    bit_d     = BW'(WIDTH);
                    state_d   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                div_d = div_q + 1'b1;
                if (div_last) begin
                    div_d   = '0;
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                div_d = div_q + 1'b1;
                if (div_last) begin
                    div_d   = '0;
                    shreg_d = shreg_q << 1;
                    bit_d   = bit_q - 1'b1;
                    state_d = (bit_q == BW'(1)) ? LATCH : SHIFT_LO;
                end
            end
            default: begin // LATCH
                div_d = div_q + 1'b1;
                if (div_last) begin
                    div_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                    valid_d = kind_q;
                end
            end
        endcase
        shifting_d  = (state_d == SHIFT_LO) || (state_d == SHIFT_HI);
        // One-deep request flags: a request landing on the accept cycle still counts
        pend_load_d = (pend_load_q & ~take_load) | trig_rise | tick;
        pend_clr_d  = (pend_clr_q & ~take_clr) | dump_rise;
    end

    // State, datapath and registered outputs (decoded from next state)
    always_ff @(posedge clk_in or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            kind_q      <= 1'b0;
            timer_q     <= '0;
            pend_load_q <= 1'b0;
            pend_clr_q  <= 1'b0;
            sclk        <= 1'b0;
            sdo         <= 1'b0;
            syn         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            out_en      <= 1'b0;
            valid       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            kind_q      <= kind_d;
            timer_q     <= timer_d;
            pend_load_q <= pend_load_d;
            pend_clr_q  <= pend_clr_d;
            sclk        <= (state_d == SHIFT_HI);
            sdo         <= shifting_d & shreg_d[WIDTH-1];
            syn         <= (state_d == LATCH);
            busy        <= (state_d != IDLE);
            done        <= done_d;
            out_en      <= shifting_d;
            valid       <= valid_d;
        end
    end

endmodule

// File: tb/tb_shr_frame_seq.sv
// Bench for shr_frame_seq: frames are captured from the pins and compared
// with the word the requester asked for.
module tb_shr_frame_seq;

    localparam int W = 16, D = 4, AP = 200;
    localparam int FRAME = 2 * D * W + D;

    logic clk_in = 0, rst_n = 0, trig = 0, dump = 0, auto_en = 0;
    logic [W-1:0] data_a = '0;
    logic sclk, sdo, syn, busy, done, out_en, valid;

    int n_pass = 0, n_tot = 0;
    int cyc = 0;

    // captured frame
    logic [W-1:0] c_word;
    int c_busy, c_syn, c_oe, c_bits, c_t0;
    bit c_to;

    shr_frame_seq #(.WIDTH(W), .DIV(D), .AUTO_PERIOD(AP)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .trig(trig), .dump(dump), .auto_en(auto_en),
        .data_a(data_a), .sclk(sclk), .sdo(sdo), .syn(syn), .busy(busy),
        .done(done), .out_en(out_en), .valid(valid)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Waits for busy, then records the frame as the chain sees it until done.
    task automatic capture();
        bit prev;
        int t;
        c_word = '0; c_busy = 0; c_syn = 0; c_oe = 0; c_bits = 0; c_to = 0; t = 0;
        while (!busy && t < 2000) begin @(negedge clk_in); t++; end
        c_t0 = cyc;
        prev = 0;
        while (!done && t < 2000) begin
            if (busy) c_busy++;
            if (syn) c_syn++;
            if (out_en) c_oe++;
            if (sclk && !prev) begin c_word = {c_word[W-2:0], sdo}; c_bits++; end
            prev = sclk;
            @(negedge clk_in); t++;
        end
        if (t >= 2000) c_to = 1;
    endtask

    task automatic pulse(input bit t, input bit d);
        trig = t; dump = d;
        repeat (2) @(negedge clk_in);
        trig = 0; dump = 0;
    endtask

    task automatic test_reset();
        int nb;
        repeat (3) @(negedge clk_in);
        n_tot++; if ({sclk, sdo, syn, busy, done, out_en, valid} !== 7'b0)
            $display("FAIL reset_outs: got %b exp 0000000", {sclk, sdo, syn, busy, done, out_en, valid}); else n_pass++;
        rst_n = 1;
        nb = 0;
        repeat (20) begin @(negedge clk_in); if (busy || done) nb++; end
        n_tot++; if (nb !== 0) $display("FAIL reset_idle: got %0d busy cycles exp 0", nb); else n_pass++;
    endtask

    task automatic test_load_fixed();
        int k;
        data_a = 16'hA5C3;
        trig = 1; k = 0;
        do begin @(negedge clk_in); k++; if (k == 2) trig = 0; end while (!busy && k < 20);
        trig = 0;
        n_tot++; if (k - 1 !== 3) $display("FAIL load_latency: got %0d exp 3", k - 1); else n_pass++;
        capture();
        n_tot++; if (c_word !== 16'hA5C3) $display("FAIL load_bits: got %h exp a5c3", c_word); else n_pass++;
        n_tot++; if (c_bits !== W) $display("FAIL load_nbits: got %0d exp %0d", c_bits, W); else n_pass++;
        n_tot++; if (c_syn !== D) $display("FAIL load_syn: got %0d exp %0d", c_syn, D); else n_pass++;
        n_tot++; if (c_busy !== FRAME) $display("FAIL load_busy: got %0d exp %0d", c_busy, FRAME); else n_pass++;
        n_tot++; if (c_oe !== 2 * D * W) $display("FAIL load_out_en: got %0d exp %0d", c_oe, 2 * D * W); else n_pass++;
        n_tot++; if ({done, busy, valid} !== 3'b101) $display("FAIL load_end: got done/busy/valid %b exp 101", {done, busy, valid}); else n_pass++;
        @(negedge clk_in);
        n_tot++; if (done !== 1'b0) $display("FAIL done_width: got %b exp 0", done); else n_pass++;
    endtask

    task automatic test_clear();
        repeat (5) @(negedge clk_in);
        data_a = 16'hFFFF;
        pulse(0, 1);
        capture();
        n_tot++; if (c_word !== 16'h0 || c_bits !== W) $display("FAIL clr_bits: got %h/%0d exp 0000/%0d", c_word, c_bits, W); else n_pass++;
        n_tot++; if (c_syn !== D) $display("FAIL clr_syn: got %0d exp %0d", c_syn, D); else n_pass++;
        n_tot++; if ({done, valid} !== 2'b10) $display("FAIL clr_end: got done/valid %b exp 10", {done, valid}); else n_pass++;
    endtask

    task automatic test_simul();
        logic [W-1:0] dv;
        repeat (5) @(negedge clk_in);
        dv = W'($urandom); data_a = dv;
        pulse(1, 1);
        capture();
        n_tot++; if (c_word !== 16'h0 || c_bits !== W) $display("FAIL simul_clr_first: got %h/%0d exp 0000/%0d", c_word, c_bits, W); else n_pass++;
        n_tot++; if (valid !== 1'b0) $display("FAIL simul_valid0: got %b exp 0", valid); else n_pass++;
        @(negedge clk_in);
        n_tot++; if (busy !== 1'b1) $display("FAIL simul_gap: got busy %b exp 1 after one idle cycle", busy); else n_pass++;
        capture();
        n_tot++; if (c_word !== dv || c_bits !== W) $display("FAIL simul_load: got %h/%0d exp %h/%0d", c_word, c_bits, dv, W); else n_pass++;
        n_tot++; if (valid !== 1'b1) $display("FAIL simul_valid1: got %b exp 1", valid); else n_pass++;
    endtask

    task automatic test_coalesce();
        logic [W-1:0] d1, d2;
        int extra;
        repeat (5) @(negedge clk_in);
        d1 = W'($urandom); d2 = W'($urandom);
        data_a = d1;
        pulse(1, 0);
        fork
            capture();
            begin
                repeat (10) @(negedge clk_in);
                for (int i = 0; i < 3; i++) begin
                    data_a = W'($urandom);
                    pulse(1, 0);
                    repeat (3) @(negedge clk_in);
                end
                data_a = d2;
            end
        join
        n_tot++; if (c_word !== d1) $display("FAIL coal_first: got %h exp %h", c_word, d1); else n_pass++;
        capture();
        n_tot++; if (c_word !== d2 || c_to) $display("FAIL coal_second: got %h exp %h", c_word, d2); else n_pass++;
        extra = 0;
        repeat (300) begin @(negedge clk_in); if (busy) extra++; end
        n_tot++; if (extra !== 0) $display("FAIL coal_extra: got %0d busy cycles exp 0", extra); else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] dv, exp_w;
        bit is_clr;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(1, 6)) @(negedge clk_in);
            dv = W'($urandom); is_clr = 1'($urandom_range(0, 1));
            data_a = dv;
            exp_w = is_clr ? '0 : dv;
            pulse(!is_clr, is_clr);
            fork
                capture();
                begin
                    // scramble data_a once the word has been taken
                    repeat (20) @(negedge clk_in);
                    data_a = W'($urandom);
                end
            join
            n_tot++; if (c_word !== exp_w || c_bits !== W) $display("FAIL rand_bits[%0d]: got %h/%0d exp %h/%0d", i, c_word, c_bits, exp_w, W); else n_pass++;
            n_tot++; if (valid !== !is_clr) $display("FAIL rand_valid[%0d]: got %b exp %b", i, valid, !is_clr); else n_pass++;
        end
    endtask

    task automatic test_auto();
        int t[3];
        int extra;
        logic [W-1:0] dv;
        repeat (5) @(negedge clk_in);
        dv = W'($urandom); data_a = dv;
        auto_en = 1;
        for (int i = 0; i < 3; i++) begin
            capture();
            t[i] = c_t0;
            if (i == 0) begin
                n_tot++; if (c_word !== dv || c_to) $display("FAIL auto_bits: got %h exp %h", c_word, dv); else n_pass++;
            end
        end
        n_tot++; if (t[1] - t[0] !== AP) $display("FAIL auto_period1: got %0d exp %0d", t[1] - t[0], AP); else n_pass++;
        n_tot++; if (t[2] - t[1] !== AP) $display("FAIL auto_period2: got %0d exp %0d", t[2] - t[1], AP); else n_pass++;
        auto_en = 0;
        extra = 0;
        repeat (500) begin @(negedge clk_in); if (busy) extra++; end
        n_tot++; if (extra !== 0) $display("FAIL auto_off: got %0d busy cycles exp 0", extra); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int r, k, extra;
        bit prev;
        repeat (3) @(negedge clk_in);
        data_a = W'($urandom);
        pulse(1, 0);
        k = 0;
        while (!busy && k < 50) begin @(negedge clk_in); k++; end
        pulse(1, 0);   // leaves a load pending behind the current frame
        r = 0; prev = sclk; k = 0;
        while (r < 8 && k < 500) begin
            @(negedge clk_in); k++;
            if (sclk && !prev) r++;
            prev = sclk;
        end
        n_tot++; if ({busy, sclk} !== 2'b11) $display("FAIL mid_position: got busy/sclk %b exp 11", {busy, sclk}); else n_pass++;
        rst_n = 0;
        #1;
        n_tot++; if ({sclk, sdo, syn, busy, done, out_en, valid} !== 7'b0)
            $display("FAIL mid_reset_outs: got %b exp 0000000", {sclk, sdo, syn, busy, done, out_en, valid}); else n_pass++;
        repeat (3) @(negedge clk_in);
        rst_n = 1;
        extra = 0;
        repeat (300) begin @(negedge clk_in); if (busy || done) extra++; end
        n_tot++; if (extra !== 0) $display("FAIL mid_no_frame: got %0d active cycles exp 0", extra); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_fixed();
        test_clear();
        test_simul();
        test_coalesce();
        test_random();
        test_auto();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
